// File: rtl/press_debouncer.sv
// press_debouncer
//   Conditions a raw, bouncy, asynchronous pushbutton level for the
//   press-driven FSM. The level is first synchronized, then debounced.
//   A level change is accepted only after DEBOUNCE_CYCLES consecutive
//   stable synchronized samples. All outputs are registered.
//
// Parameters
//   SYNC_STAGES      synchronizer depth on btn_in (2..4)
//   DEBOUNCE_CYCLES  stable samples needed to accept a change (2..65535)
//   CNT_W            stability counter width (derived, leave at default)
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   btn_in         raw pushbutton level, asynchronous to clk
//   press          one-cycle pulse on an accepted press (to FSM press input)
//   release_pulse  one-cycle pulse on an accepted release
//                  ("release" is a reserved word, hence the suffix)
//   held           debounced button level
//   glitch_cnt     rejected bounce count, saturates at 255, cleared by rst
module press_debouncer #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_in,
   output logic       press,
   output logic       release_pulse,
   output logic       held,
   output logic [7:0] glitch_cnt
);

   typedef enum logic [1:0] {
      IDLE,
      ARMING,
      PRESSED,
      RELEASING
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   btn_s;

   state_t                 state;
   state_t                 state_d;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       cnt_d;
   logic                   press_d;
   logic                   release_d;
   logic                   held_d;
   logic                   glitch_inc;
   logic [7:0]             glitch_d;

   // Synchronizer: the only logic that sees btn_in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], btn_in};
      end
   end

   assign btn_s = sync[SYNC_STAGES-1];

   // State, counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         held          <= 1'b0;
         glitch_cnt    <= '0;
      end else begin
         state         <= state_d;
         cnt           <= cnt_d;
         press         <= press_d;
         release_pulse <= release_d;
         held          <= held_d;
         glitch_cnt    <= glitch_d;
      end
   end

   // Next state. A bounce seen while arming or releasing aborts the
   // pending change, returns to the settled state and is counted.
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      press_d    = 1'b0;
      release_d  = 1'b0;
      held_d     = held;
      glitch_inc = 1'b0;

      unique case (state)
         IDLE: begin
            held_d = 1'b0;
            if (btn_s) begin
               state_d = ARMING;
               cnt_d   = CNT_ONE;
            end
         end

         ARMING: begin
            if (btn_s) begin
               if (cnt == CNT_LAST) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
                  press_d = 1'b1;
                  held_d  = 1'b1;
               end else begin
                  cnt_d = cnt + CNT_ONE;
               end
            end else begin
               state_d    = IDLE;
               cnt_d      = '0;
               glitch_inc = 1'b1;
            end
         end

         PRESSED: begin
            held_d = 1'b1;
            if (!btn_s) begin
               state_d = RELEASING;
               cnt_d   = CNT_ONE;
            end
         end

         RELEASING: begin
            if (!btn_s) begin
               if (cnt == CNT_LAST) begin
                  state_d   = IDLE;
                  cnt_d     = '0;
                  release_d = 1'b1;
                  held_d    = 1'b0;
               end else begin
                  cnt_d = cnt + CNT_ONE;
               end
            end else begin
               state_d    = PRESSED;
               cnt_d      = '0;
               glitch_inc = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            held_d  = 1'b0;
         end
      endcase
   end

   // Saturating glitch counter: holds at 255, never wraps.
   always_comb begin
      glitch_d = glitch_cnt;
      if (glitch_inc && (glitch_cnt != 8'hff)) begin
         glitch_d = glitch_cnt + 8'd1;
      end
   end

endmodule
